// File: rtl/game_pkg.sv
// Shared game constants for the GameControl layer: sprite half-sizes, map extent,
// enemy projectile pool sizing and fire cooldown, plus sign-extension helpers.
// Geometry constants are typed 12-bit signed so position math never wraps.
package game_pkg;

    // Half-extents of the sprites, in pixels.
    localparam logic signed [11:0] BULLET_X       = 12'sd4;
    localparam logic signed [11:0] BULLET_Y       = 12'sd4;
    localparam logic signed [11:0] PLAYER_X       = 12'sd16;
    localparam logic signed [11:0] PLAYER_Y       = 12'sd32;
    localparam logic signed [11:0] SQUAT_PLAYER_Y = 12'sd16;

    // Leftward bullet displacement per frame tick.
    localparam logic signed [11:0] BULLET_STEP_X  = 12'sd8;

    // Visible map spans x in [-MAP_X, MAP_X].
    localparam logic signed [11:0] MAP_X          = 12'sd320;

    localparam int ENEMY_BULLET_SLOTS  = 4;
    localparam int ENEMY_FIRE_COOLDOWN = 8;

    function automatic logic signed [11:0] sx11(input logic signed [10:0] v);
        return {v[10], v};
    endfunction

    function automatic logic signed [11:0] sx10(input logic signed [9:0] v);
        return {{2{v[9]}}, v};
    endfunction

endpackage

// File: rtl/bullet_slot.sv
// One enemy bullet: idle until loaded, then steps left each tick, hit-tests the player box, retires.
// Latency: state and hit pulse update on the tick edge; hit is a one-cycle registered pulse.
// Backpressure: none; load is honoured only on a tick while idle.
// Ports: clk, rst_n (sync, active-low), tick, load/load_x/load_y (spawn), x_player/y_player/half_h
//        (player box), x/y (bullet centre), active, hit.
module bullet_slot
    import game_pkg::*;
#(
    parameter logic signed [11:0] STEP_X = BULLET_STEP_X
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               tick,
    input  logic               load,
    input  logic signed [10:0] load_x,
    input  logic signed [9:0]  load_y,
    input  logic signed [10:0] x_player,
    input  logic signed [9:0]  y_player,
    input  logic signed [11:0] half_h,
    output logic signed [10:0] x,
    output logic signed [9:0]  y,
    output logic               active,
    output logic               hit
);

    // Retire once the bullet's left edge would fall off the map.
    localparam logic signed [11:0] RETIRE_X = BULLET_X - MAP_X;

    logic signed [11:0] xn;
    logic signed [11:0] yb;
    logic signed [11:0] px;
    logic signed [11:0] py;
    logic               strike;
    logic               off_map;

    // Everything widened to 12 bits first so none of the compares can wrap.
    always_comb begin
        xn      = sx11(x) - STEP_X;
        yb      = sx10(y);
        px      = sx11(x_player);
        py      = sx10(y_player);
        strike  = (xn - BULLET_X <= px + PLAYER_X) &&
                  (xn + BULLET_X >= px - PLAYER_X) &&
                  (yb - BULLET_Y <= py + half_h) &&
                  (yb + BULLET_Y >= py - half_h);
        off_map = (xn < RETIRE_X);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            x      <= '0;
            y      <= '0;
            active <= 1'b0;
            hit    <= 1'b0;
        end else begin
            hit <= 1'b0;
            if (tick) begin
                if (active) begin
                    // A hit takes precedence over an off-map retire on the same step.
                    if (strike) begin
                        active <= 1'b0;
                        hit    <= 1'b1;
                    end else if (off_map) begin
                        active <= 1'b0;
                    end else begin
                        x <= xn[10:0];
                    end
                end else if (load) begin
                    // Freshly spawned bullets neither move nor hit-test on this tick.
                    active <= 1'b1;
                    x      <= load_x;
                    y      <= load_y;
                end
            end
        end
    end

endmodule

// File: rtl/enemy_bullet_pool.sv
// Enemy projectile pool: spawns into the lowest free slot under a fire cooldown, aggregates hits.
// Latency: positions, isE, isHit and hitMask reflect a tick one edge later; hit pulses last one cycle.
// Backpressure: none; a fire request with no free slot is dropped and leaves the cooldown untouched.
// Ports: clk, rst_n (sync, active-low), tick, attack, defend, xEnemy/yEnemy, xPlayer/yPlayer, isQ,
//        x[]/y[] (per-slot centres), isE (active mask), isHit, hitMask, full.
module enemy_bullet_pool
    import game_pkg::*;
#(
    parameter int                 NUM_SLOTS = ENEMY_BULLET_SLOTS,
    parameter logic signed [11:0] STEP_X    = BULLET_STEP_X,
    parameter int unsigned        COOLDOWN  = ENEMY_FIRE_COOLDOWN
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 tick,
    input  logic                 attack,
    input  logic                 defend,
    input  logic signed [10:0]   xEnemy,
    input  logic signed [9:0]    yEnemy,
    input  logic signed [10:0]   xPlayer,
    input  logic signed [9:0]    yPlayer,
    input  logic                 isQ,
    output logic signed [10:0]   x [NUM_SLOTS],
    output logic signed [9:0]    y [NUM_SLOTS],
    output logic [NUM_SLOTS-1:0] isE,
    output logic                 isHit,
    output logic [NUM_SLOTS-1:0] hitMask,
    output logic                 full
);

    logic [7:0]           cd;
    logic [NUM_SLOTS-1:0] free;
    logic [NUM_SLOTS-1:0] pick;
    logic [NUM_SLOTS-1:0] load;
    logic                 can_spawn;
    logic signed [10:0]   spawn_x;
    logic signed [11:0]   half_h;

    always_comb begin
        // Free mask is taken before this tick's retires, so a slot freed now is
        // only reusable from the next tick on.
        free      = ~isE;
        // Isolate the lowest set bit: the lowest-index free slot.
        pick      = free & (~free + NUM_SLOTS'(1));
        can_spawn = tick & attack & ~defend & (cd == 8'd0) & (|free);
        load      = can_spawn ? pick : '0;
        // Bullet leaves from just in front of the enemy's left edge.
        spawn_x   = 11'(sx11(xEnemy) - PLAYER_X - BULLET_X);
        half_h    = isQ ? SQUAT_PLAYER_Y : PLAYER_Y;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cd <= '0;
        end else if (tick) begin
            if (can_spawn) begin
                cd <= 8'(COOLDOWN);
            end else if (cd != 8'd0) begin
                cd <= cd - 8'd1;
            end
        end
    end

    for (genvar i = 0; i < NUM_SLOTS; i++) begin : g_slot
        bullet_slot #(
            .STEP_X (STEP_X)
        ) u_slot (
            .clk      (clk),
            .rst_n    (rst_n),
            .tick     (tick),
            .load     (load[i]),
            .load_x   (spawn_x),
            .load_y   (yEnemy),
            .x_player (xPlayer),
            .y_player (yPlayer),
            .half_h   (half_h),
            .x        (x[i]),
            .y        (y[i]),
            .active   (isE[i]),
            .hit      (hitMask[i])
        );
    end

    // Pure reductions of slot flops, so they track the registered slot state exactly.
    assign isHit = |hitMask;
    assign full  = &isE;

endmodule

// File: tb/tb_enemy_bullet_pool.sv
module tb_enemy_bullet_pool;
    import game_pkg::*;

    localparam int N  = 4;
    localparam int CD = 2;

    logic               clk = 1'b0;
    logic               rst_n, tick, attack, defend, isQ;
    logic signed [10:0] xEnemy, xPlayer;
    logic signed [9:0]  yEnemy, yPlayer;
    logic signed [10:0] x [N];
    logic signed [9:0]  y [N];
    logic [N-1:0]       isE, hitMask;
    logic               isHit, full;

    int total = 0;
    int bad   = 0;

    // Behavioural model state.
    bit         m_a [N];
    int         m_x [N];
    int         m_y [N];
    int         m_cd;
    bit [N-1:0] m_hm;

    enemy_bullet_pool #(.NUM_SLOTS(N), .COOLDOWN(CD)) dut (
        .clk(clk), .rst_n(rst_n), .tick(tick), .attack(attack), .defend(defend),
        .xEnemy(xEnemy), .yEnemy(yEnemy), .xPlayer(xPlayer), .yPlayer(yPlayer), .isQ(isQ),
        .x(x), .y(y), .isE(isE), .isHit(isHit), .hitMask(hitMask), .full(full)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s actual=%0d expected=%0d at %0t", nm, act, exp, $time);
        end
    endtask

    // One edge of the game rules, applied to the inputs as seen at that edge.
    task automatic model_step();
        bit [N-1:0] fr;
        int px, py, h, xn, yb;
        bit took;
        m_hm = '0;
        if (!rst_n) begin
            for (int i = 0; i < N; i++) begin
                m_a[i] = 0; m_x[i] = 0; m_y[i] = 0;
            end
            m_cd = 0;
        end else if (tick) begin
            px = xPlayer; py = yPlayer;
            h  = isQ ? int'(SQUAT_PLAYER_Y) : int'(PLAYER_Y);
            for (int i = 0; i < N; i++) fr[i] = !m_a[i];
            for (int i = 0; i < N; i++) begin
                if (m_a[i]) begin
                    xn = m_x[i] - int'(BULLET_STEP_X);
                    yb = m_y[i];
                    if (xn - int'(BULLET_X) <= px + int'(PLAYER_X) &&
                        xn + int'(BULLET_X) >= px - int'(PLAYER_X) &&
                        yb - int'(BULLET_Y) <= py + h && yb + int'(BULLET_Y) >= py - h) begin
                        m_a[i] = 0; m_hm[i] = 1'b1;
                    end else if (xn < int'(BULLET_X) - int'(MAP_X)) begin
                        m_a[i] = 0;
                    end else begin
                        m_x[i] = xn;
                    end
                end
            end
            if (attack && !defend && m_cd == 0 && fr != '0) begin
                took = 0;
                for (int i = 0; i < N; i++) begin
                    if (fr[i] && !took) begin
                        took   = 1;
                        m_a[i] = 1;
                        m_x[i] = int'(xEnemy) - int'(PLAYER_X) - int'(BULLET_X);
                        m_y[i] = yEnemy;
                    end
                end
                m_cd = CD;
            end else if (m_cd > 0) begin
                m_cd--;
            end
        end
    endtask

    task automatic compare();
        bit [N-1:0] me;
        for (int i = 0; i < N; i++) me[i] = m_a[i];
        chk("isE", int'(isE), int'(me));
        chk("hitMask", int'(hitMask), int'(m_hm));
        chk("isHit", int'(isHit), int'(m_hm != '0));
        chk("full", int'(full), int'(me == '1));
        for (int i = 0; i < N; i++) begin
            chk($sformatf("x%0d", i), int'(x[i]), m_x[i]);
            chk($sformatf("y%0d", i), int'(y[i]), m_y[i]);
        end
    endtask

    task automatic cyc(input logic t);
        tick = t;
        @(posedge clk);
        model_step();
        #1;
        compare();
    endtask

    task automatic tk(input logic atk);
        attack = atk;
        cyc(1'b1);
    endtask

    initial begin
        int v;
        rst_n = 1'b0; tick = 1'b0; attack = 1'b0; defend = 1'b0; isQ = 1'b0;
        xEnemy = 11'sd300; yEnemy = 10'sd0; xPlayer = -11'sd300; yPlayer = 10'sd0;

        // Reset state
        cyc(1'b0); cyc(1'b0);
        chk("rst_isE", int'(isE), 0);
        chk("rst_full", int'(full), 0);
        chk("rst_x0", int'(x[0]), 0);
        rst_n = 1'b1;
        cyc(1'b0);

        // Single shot: spawn at 280, hits on the 70th step (x=-280)
        tk(1'b1);
        chk("shot_x0", int'(x[0]), 280);
        chk("shot_isE", int'(isE), 1);
        attack = 1'b0;
        for (int n = 1; n < 70; n++) begin
            cyc(1'b1);
            cyc(1'b0);
        end
        chk("shot_x69", int'(x[0]), 280 - 8 * 69);
        cyc(1'b1);
        chk("shot_hit", int'(isHit), 1);
        chk("shot_mask", int'(hitMask), 1);
        chk("shot_idle", int'(isE), 0);
        cyc(1'b0);
        chk("shot_hit_clr", int'(isHit), 0);

        // Squat dodge: y band clears the squat box, bullet retires at step 75
        yEnemy = -10'sd26; isQ = 1'b1;
        tk(1'b1);
        attack = 1'b0;
        for (int n = 1; n <= 74; n++) cyc(1'b1);
        chk("squat_x74", int'(x[0]), -312);
        chk("squat_alive", int'(isE), 1);
        cyc(1'b1);
        chk("squat_retire", int'(isE), 0);
        chk("squat_nohit", int'(isHit), 0);

        // Cooldown and pool: attack held, spawns on ticks 0,3,6,9
        isQ = 1'b0; yEnemy = 10'sd0; yPlayer = 10'sd500;
        for (int t = 0; t <= 12; t++) begin
            tk(1'b1);
            if (t == 3) chk("pool_t3", int'(isE), 3);
            if (t == 9) chk("pool_full", int'(full), 1);
        end
        chk("pool_drop", int'(isE), 15);
        // Slot0 hit while full: request dropped, slot0 reused on the next tick
        xPlayer = 11'sd160; yPlayer = 10'sd0;
        tk(1'b1);
        chk("reuse_mask", int'(hitMask), 1);
        chk("reuse_isE", int'(isE), 14);
        tk(1'b1);
        chk("reuse_spawn", int'(isE), 15);
        chk("reuse_x0", int'(x[0]), 280);

        // Multi-hit: two bullets 8 px apart struck on the same tick
        attack = 1'b0; rst_n = 1'b0;
        cyc(1'b0);
        rst_n = 1'b1; xPlayer = 11'sd240; yPlayer = 10'sd500; xEnemy = 11'sd300;
        tk(1'b1); tk(1'b0); tk(1'b0);
        xEnemy = 11'sd284;
        tk(1'b1);
        yPlayer = 10'sd0;
        tk(1'b0);
        chk("multi_mask", int'(hitMask), 3);
        chk("multi_hit", int'(isHit), 1);
        cyc(1'b0);
        chk("multi_clr", int'(hitMask), 0);

        // Defend blocks spawning
        yPlayer = 10'sd500; xEnemy = 11'sd300;
        tk(1'b0); tk(1'b0);
        defend = 1'b1;
        tk(1'b1);
        chk("defend_block", int'(isE), 0);
        defend = 1'b0;
        tk(1'b1);
        chk("defend_release", int'(isE), 1);

        // Reset mid-flight, then spawn immediately
        for (int t = 0; t < 6; t++) tk(1'b1);
        chk("mid_three", int'(isE), 7);
        rst_n = 1'b0;
        cyc(1'b1);
        chk("mid_rst_isE", int'(isE), 0);
        chk("mid_rst_y0", int'(y[0]), 0);
        rst_n = 1'b1;
        tk(1'b1);
        chk("mid_respawn", int'(isE), 1);

        // Randomized traffic against the model
        for (int n = 0; n < 4000; n++) begin
            rst_n  = ($urandom_range(0, 299) != 0);
            attack = $urandom_range(0, 1) == 1;
            defend = ($urandom_range(0, 3) == 0);
            isQ    = $urandom_range(0, 1) == 1;
            if ($urandom_range(0, 15) == 0) begin
                v = $urandom_range(0, 400); xEnemy  = 11'(v + 100);
                v = $urandom_range(0, 200); yEnemy  = 10'(v - 100);
                v = $urandom_range(0, 600); xPlayer = 11'(v - 300);
                v = $urandom_range(0, 200); yPlayer = 10'(v - 100);
            end
            cyc($urandom_range(0, 3) != 0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
